// File: rtl/instr_loader_if.sv
// Stream and memory-side signal bundle for instr_loader.
// slave is the loader's view; master is the sequencer/memory side.
interface instr_loader_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] count;
  logic              in_valid;
  logic              in_ready;
  logic              in_format;
  logic [3:0]        in_opcode;
  logic              in_sign;
  logic [2:0]        in_operand;
  logic [7:0]        in_immediate;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        mem_data;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, count,
    input  in_valid, in_format, in_opcode, in_sign, in_operand, in_immediate,
    output in_ready,
    input  mem_ready,
    output mem_we, mem_addr, mem_data,
    output busy, done
  );

  modport master (
    output start, base_addr, count,
    output in_valid, in_format, in_opcode, in_sign, in_operand, in_immediate,
    input  in_ready,
    output mem_ready,
    input  mem_we, mem_addr, mem_data,
    input  busy, done
  );
endinterface

// File: rtl/instr_loader.sv
// Packs decoded instruction fields into 9-bit words, buffers them in a small FIFO
// and writes them to consecutive instruction-memory addresses starting at a base PC.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting bundles and writing words until written == count
// DONE  | one-cycle done pulse, back to IDLE
module instr_loader #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  instr_loader_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, state_nxt;
  logic [8:0]        fifo_mem [DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] base_q, count_q, accepted, written;
  logic              fifo_full, fifo_empty;
  logic              in_ready_c, mem_we_c, busy_c, done_c;
  logic              push, pop, start_job;
  logic [8:0]        packed_word;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign push      = bus.in_valid & in_ready_c;
  assign pop       = mem_we_c & bus.mem_ready;
  assign start_job = (state == IDLE) & bus.start;

  always_comb begin
    if (bus.in_format)
      packed_word = {1'b1, bus.in_immediate};
    else
      packed_word = {1'b0, bus.in_opcode, bus.in_sign, bus.in_operand};
  end

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    mem_we_c   = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start)
          state_nxt = (bus.count == '0) ? DONE : LOAD;
      end
      LOAD: begin
        in_ready_c = !fifo_full && (accepted < count_q);
        mem_we_c   = !fifo_empty;
        if (written == count_q)
          state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      count_q  <= '0;
      accepted <= '0;
      written  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (start_job) begin
      base_q   <= bus.base_addr;
      count_q  <= bus.count;
      accepted <= '0;
      written  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        accepted <= accepted + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        written <= written + 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr[PTR_W-1:0]] <= packed_word;
  end

  assign bus.in_ready = in_ready_c;
  assign bus.mem_we   = mem_we_c;
  assign bus.mem_addr = mem_we_c ? (base_q + written) : '0;
  assign bus.mem_data = mem_we_c ? fifo_mem[rd_ptr[PTR_W-1:0]] : '0;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
endmodule

// File: tb/tb_instr_loader.sv
// Randomized scoreboard bench for instr_loader: the driver queues expected writes as
// bundles are accepted, an independent monitor pops and compares each memory write.
module tb_instr_loader;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_loader_if #(.ADDR_W(16)) bus ();
  instr_loader #(.DEPTH(DEPTH), .ADDR_W(16)) dut (.clk(clk), .reset(rst), .bus(bus));

  typedef struct {
    logic [15:0] addr;
    logic [8:0]  data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] wr_log[$];
  logic [8:0]  last_wdata;
  int          vectors = 0;
  int          errors = 0;
  int          cyc_now = 0;
  int          ready_mode = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] pack_model(input logic fmt, input logic [3:0] op,
                                            input logic sg, input logic [2:0] opd,
                                            input logic [7:0] imm);
    int v;
    if (fmt) v = 256 + int'(imm);
    else     v = int'(op) * 16 + int'(sg) * 8 + int'(opd);
    return v[8:0];
  endfunction

  task automatic new_fields();
    bus.in_format    = 1'($urandom_range(0, 1));
    bus.in_opcode    = 4'($urandom);
    bus.in_sign      = 1'($urandom);
    bus.in_operand   = 3'($urandom);
    bus.in_immediate = 8'($urandom);
  endtask

  task automatic push_expected(input logic [15:0] b, input int acc);
    exp_t e;
    e.addr = b + 16'(acc);
    e.data = pack_model(bus.in_format, bus.in_opcode, bus.in_sign, bus.in_operand, bus.in_immediate);
    e.cyc  = cyc_now;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc_now <= cyc_now + 1;

  initial begin
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.mem_ready = 1'b0;
        1:       bus.mem_ready = 1'b1;
        default: bus.mem_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every write committed at the next edge must match the scoreboard head.
  initial begin
    logic        prev_stall;
    logic [15:0] prev_addr;
    logic [8:0]  prev_data;
    exp_t        e;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_we", bus.mem_we, 1);
          chk("stall_addr", bus.mem_addr, prev_addr);
          chk("stall_data", bus.mem_data, prev_data);
        end
        if (bus.mem_we && bus.mem_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", bus.mem_addr, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", bus.mem_addr, e.addr);
            chk("wr_data", bus.mem_data, e.data);
            chk("wr_latency", (cyc_now > e.cyc), 1);
          end
          wr_log.push_back(bus.mem_addr);
          last_wdata = bus.mem_data;
        end
        prev_stall = bus.mem_we && !bus.mem_ready;
        prev_addr  = bus.mem_addr;
        prev_data  = bus.mem_data;
      end
    end
  end

  task automatic run_job(input logic [15:0] b, input logic [15:0] c, input int rdy_mode,
                         input bit rand_valid, input bit keep_fields, input bit bp_test);
    int acc = 0;
    int cyc = 0;
    bit got_done = 0;
    bit accepted_now;
    ready_mode = rdy_mode;
    wr_log.delete();
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_addr = b;
    bus.count = c;
    if (!keep_fields) new_fields();
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.base_addr = 16'($urandom);
    bus.count = 16'($urandom);
    while (!got_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      accepted_now = 1'b0;
      if (bus.done) begin
        got_done = 1;
      end else begin
        chk("busy_in_job", bus.busy, 1);
        if (acc >= int'(c)) chk("no_accept_beyond_count", bus.in_ready, 0);
        if (bus.in_valid && bus.in_ready) begin
          push_expected(b, acc);
          acc++;
          accepted_now = 1'b1;
        end
        if (bp_test && cyc == 12) begin
          chk("bp_accepts", acc, DEPTH);
          chk("bp_in_ready", bus.in_ready, 0);
          chk("bp_we", bus.mem_we, 1);
          chk("bp_addr_hold", bus.mem_addr, b);
          ready_mode = 1;
        end
      end
      @(posedge clk);
      #1;
      if (accepted_now || !bus.in_valid) begin
        if (!keep_fields) new_fields();
        bus.in_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
    if (!got_done) chk("done_timeout", 0, 1);
    if (c == 0) chk("zero_count_done_cycle", cyc, 1);
    chk("accept_total", acc, c);
    chk("write_total", wr_log.size(), c);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("busy_after_done", bus.busy, 0);
  endtask

  initial begin
    int acc;
    int cyc;
    bit accepted_now;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.count = '0;
    bus.in_valid = 1'b0;
    new_fields();
    #12;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_data", bus.mem_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Packing, register format then immediate format
    bus.in_format = 1'b0; bus.in_opcode = 4'd1; bus.in_sign = 1'b0; bus.in_operand = 3'd1;
    bus.in_immediate = 8'hA5;
    run_job(16'h0040, 16'd1, 1, 0, 1, 0);
    chk("pack_fmt0", last_wdata, 9'b000010001);
    bus.in_format = 1'b1; bus.in_immediate = 8'h79; bus.in_opcode = 4'hF; bus.in_sign = 1'b1;
    bus.in_operand = 3'd7;
    run_job(16'h0041, 16'd1, 1, 0, 1, 0);
    chk("pack_fmt1", last_wdata, 9'b101111001);

    run_job(16'h0010, 16'd3, 1, 0, 0, 0);
    chk("job_addr0", wr_log.size() > 0 ? wr_log[0] : 16'hDEAD, 16'h0010);
    chk("job_addr1", wr_log.size() > 1 ? wr_log[1] : 16'hDEAD, 16'h0011);
    chk("job_addr2", wr_log.size() > 2 ? wr_log[2] : 16'hDEAD, 16'h0012);

    run_job(16'h0100, 16'd6, 0, 0, 0, 1);

    run_job(16'hFFFF, 16'd2, 1, 0, 0, 0);
    chk("wrap_addr0", wr_log.size() > 0 ? wr_log[0] : 16'hDEAD, 16'hFFFF);
    chk("wrap_addr1", wr_log.size() > 1 ? wr_log[1] : 16'hDEAD, 16'h0000);

    run_job(16'h0200, 16'd0, 1, 0, 0, 0);

    for (int j = 0; j < 8; j++)
      run_job(16'($urandom), 16'($urandom_range(1, 12)), 2, 1, 0, 0);

    // Reset after two of five writes
    ready_mode = 1;
    wr_log.delete();
    @(posedge clk);
    #1;
    bus.start = 1'b1; bus.base_addr = 16'h0300; bus.count = 16'd5;
    new_fields();
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    acc = 0;
    cyc = 0;
    while (wr_log.size() < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      accepted_now = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        push_expected(16'h0300, acc);
        acc++;
        accepted_now = 1'b1;
      end
      @(posedge clk);
      #1;
      if (accepted_now) new_fields();
    end
    chk("pre_reset_writes", wr_log.size(), 2);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_in_ready", bus.in_ready, 0);
    chk("async_rst_mem_we", bus.mem_we, 0);
    chk("async_rst_mem_addr", bus.mem_addr, 0);
    chk("async_rst_mem_data", bus.mem_data, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_done", bus.done, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_no_we", bus.mem_we, 0);
      chk("post_rst_no_ready", bus.in_ready, 0);
    end
    run_job(16'h0500, 16'd5, 1, 0, 0, 0);
    chk("restart_addr0", wr_log.size() > 0 ? wr_log[0] : 16'hDEAD, 16'h0500);
    chk("restart_addr4", wr_log.size() > 4 ? wr_log[4] : 16'hDEAD, 16'h0504);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
